// File: rtl/multi_register_bank.sv
// Bank of DEPTH x WIDTH registers with masked multi-register ops, two combinational read ports and sticky wrap flags.
// Writes take effect on the rising Clock edge; reads have zero latency. The bank is always ready and has no backpressure.
module multi_register_bank #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   localparam int SELW = $clog2(DEPTH)
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] I,
   input  logic [2:0]       FunSel,
   input  logic [DEPTH-1:0] RegSel,
   input  logic [SELW-1:0]  OutASel,
   input  logic [SELW-1:0]  OutBSel,
   output logic [WIDTH-1:0] OutA,
   output logic [WIDTH-1:0] OutB,
   output logic [DEPTH-1:0] Wrap
);

   localparam int HALF = WIDTH / 2;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   typedef enum logic [2:0] {
      OP_DEC    = 3'b000,
      OP_INC    = 3'b001,
      OP_LOAD   = 3'b010,
      OP_CLR    = 3'b011,
      OP_LO_CLR = 3'b100,
      OP_LO_KEEP = 3'b101,
      OP_HI     = 3'b110,
      OP_SEXT   = 3'b111
   } op_t;

   op_t op;
   assign op = op_t'(FunSel);

   logic [WIDTH-1:0] regs   [DEPTH];
   logic             wrap_q [DEPTH];

   for (genvar g = 0; g < DEPTH; g++) begin : g_reg
      logic [WIDTH-1:0] nxt;
      logic             wrap_nxt;

      // Wrap is only ever set by a counting op crossing the boundary; any load-style op clears it.
      always_comb begin
         nxt      = regs[g];
         wrap_nxt = 1'b0;
         case (op)
            OP_DEC: begin
               nxt      = regs[g] - ONE;
               wrap_nxt = wrap_q[g] | (regs[g] == '0);
            end
            OP_INC: begin
               nxt      = regs[g] + ONE;
               wrap_nxt = wrap_q[g] | (&regs[g]);
            end
            OP_LOAD:    nxt = I;
            OP_CLR:     nxt = '0;
            OP_LO_CLR:  nxt = {{HALF{1'b0}}, I[HALF-1:0]};
            OP_LO_KEEP: nxt = {regs[g][WIDTH-1:HALF], I[HALF-1:0]};
            OP_HI:      nxt = {I[HALF-1:0], regs[g][HALF-1:0]};
            OP_SEXT:    nxt = {{HALF{I[HALF-1]}}, I[HALF-1:0]};
            default:    nxt = regs[g];
         endcase
      end

      always_ff @(posedge Clock or negedge Reset) begin
         if (!Reset) begin
            regs[g]   <= '0;
            wrap_q[g] <= 1'b0;
         end else if (RegSel[g]) begin
            regs[g]   <= nxt;
            wrap_q[g] <= wrap_nxt;
         end
      end
   end

   // Selects that name no register (non-power-of-two DEPTH) fall through to zero.
   always_comb begin
      OutA = '0;
      OutB = '0;
      Wrap = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (OutASel == SELW'(k)) OutA = regs[k];
         if (OutBSel == SELW'(k)) OutB = regs[k];
         Wrap[k] = wrap_q[k];
      end
   end

endmodule

// File: tb/tb_multi_register_bank.sv
// Randomized and directed check of multi_register_bank at 16x4 and 8x3 against an arithmetic reference model.
module tb_multi_register_bank;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic [2:0]  FunSel = '0;
   logic [15:0] I16 = '0;
   logic [3:0]  RegSel16 = '0;
   logic [1:0]  a16 = '0, b16 = '0;
   logic [15:0] OutA16, OutB16;
   logic [3:0]  Wrap16;
   logic [7:0]  I8 = '0;
   logic [2:0]  RegSel8 = '0;
   logic [1:0]  a8 = '0, b8 = '0;
   logic [7:0]  OutA8, OutB8;
   logic [2:0]  Wrap8;

   multi_register_bank #(.WIDTH(16), .DEPTH(4)) dut16 (
      .Clock(Clock), .Reset(Reset), .I(I16), .FunSel(FunSel), .RegSel(RegSel16),
      .OutASel(a16), .OutBSel(b16), .OutA(OutA16), .OutB(OutB16), .Wrap(Wrap16));

   multi_register_bank #(.WIDTH(8), .DEPTH(3)) dut8 (
      .Clock(Clock), .Reset(Reset), .I(I8), .FunSel(FunSel), .RegSel(RegSel8),
      .OutASel(a8), .OutBSel(b8), .OutA(OutA8), .OutB(OutB8), .Wrap(Wrap8));

   always #5 Clock = ~Clock;

   int checks = 0;
   int errs = 0;

   logic [15:0] m16 [4];
   logic [3:0]  w16;
   logic [15:0] m8 [3];
   logic [2:0]  w8;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ref_next(input logic [15:0] r, input logic [2:0] fs,
                                            input logic [15:0] d, input int w);
      logic [31:0] mask, hmask, lo, rr, res;
      int h;
      h     = w / 2;
      mask  = (32'd1 << w) - 32'd1;
      hmask = (32'd1 << h) - 32'd1;
      lo    = {16'd0, d} & hmask;
      rr    = {16'd0, r};
      case (fs)
         3'd0:    res = (rr - 32'd1) & mask;
         3'd1:    res = (rr + 32'd1) & mask;
         3'd2:    res = {16'd0, d} & mask;
         3'd3:    res = 32'd0;
         3'd4:    res = lo;
         3'd5:    res = (rr & mask & ~hmask) | lo;
         3'd6:    res = (lo << h) | (rr & hmask);
         default: res = lo[h-1] ? (lo | (mask & ~hmask)) : lo;
      endcase
      return res[15:0];
   endfunction

   function automatic logic ref_wrap(input logic wf, input logic [15:0] r, input logic [2:0] fs,
                                     input int w);
      logic [31:0] mask;
      mask = (32'd1 << w) - 32'd1;
      if (fs == 3'd0) return (r == 16'd0) ? 1'b1 : wf;
      if (fs == 3'd1) return ({16'd0, r} == mask) ? 1'b1 : wf;
      return 1'b0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) m16[k] = '0;
      for (int k = 0; k < 3; k++) m8[k] = '0;
      w16 = '0;
      w8  = '0;
   endtask

   task automatic verify();
      a16 = 2'd0; b16 = 2'd1; a8 = 2'd0; b8 = 2'd1;
      #1;
      chk("r16_0", OutA16, m16[0]);
      chk("r16_1", OutB16, m16[1]);
      chk("r8_0", {8'd0, OutA8}, m8[0]);
      chk("r8_1", {8'd0, OutB8}, m8[1]);
      a16 = 2'd2; b16 = 2'd3; a8 = 2'd2; b8 = 2'd3;
      #1;
      chk("r16_2", OutA16, m16[2]);
      chk("r16_3", OutB16, m16[3]);
      chk("r8_2", {8'd0, OutA8}, m8[2]);
      chk("r8_oob", {8'd0, OutB8}, 16'h0000);
      chk("wrap16", {12'd0, Wrap16}, {12'd0, w16});
      chk("wrap8", {13'd0, Wrap8}, {13'd0, w8});
      a16 = 2'd2; b16 = 2'd2;
      #1;
   endtask

   task automatic do_op(input logic [2:0] fs, input logic [3:0] r16, input logic [15:0] d16,
                        input logic [2:0] r8, input logic [7:0] d8);
      FunSel = fs; RegSel16 = r16; I16 = d16; RegSel8 = r8; I8 = d8;
      #1;
      chk("pre_edge_a", OutA16, m16[a16]);
      chk("pre_edge_b", OutB16, m16[b16]);
      @(posedge Clock);
      for (int k = 0; k < 4; k++) if (r16[k]) begin
         w16[k] = ref_wrap(w16[k], m16[k], fs, 16);
         m16[k] = ref_next(m16[k], fs, d16, 16);
      end
      for (int k = 0; k < 3; k++) if (r8[k]) begin
         w8[k] = ref_wrap(w8[k], m8[k], fs, 8);
         m8[k] = ref_next(m8[k], fs, {8'd0, d8}, 8);
      end
      verify();
   endtask

   task automatic chk_r3(input string tag, input logic [15:0] exp);
      b16 = 2'd3;
      #1;
      chk(tag, OutB16, exp);
   endtask

   task automatic async_reset_check(input string tag);
      a16 = 2'd0; b16 = 2'd3;
      Reset = 1'b0;
      model_reset();
      #1;
      chk({tag, "_a"}, OutA16, 16'h0000);
      chk({tag, "_b"}, OutB16, 16'h0000);
      chk({tag, "_wrap"}, {12'd0, Wrap16}, 16'h0000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      #12;
      chk("reset_a", OutA16, 16'h0000);
      chk("reset_wrap", {12'd0, Wrap16}, 16'h0000);
      Reset = 1'b1;

      // Asynchronous reset between edges and held across an edge.
      do_op(3'b010, 4'b0001, 16'h1111, 3'b000, 8'h00);
      do_op(3'b010, 4'b0010, 16'h2222, 3'b000, 8'h00);
      do_op(3'b010, 4'b0100, 16'h3333, 3'b000, 8'h00);
      do_op(3'b010, 4'b1000, 16'h4444, 3'b000, 8'h00);
      chk_r3("load_r3", 16'h4444);
      async_reset_check("rst_mid");
      FunSel = 3'b010; RegSel16 = 4'b1111; I16 = 16'hFFFF; RegSel8 = 3'b111; I8 = 8'hFF;
      @(posedge Clock);
      #1;
      chk("rst_held_edge", OutA16, 16'h0000);
      verify();
      @(negedge Clock);
      Reset = 1'b1;
      #1;

      // Multi-register write; both ports on R2.
      do_op(3'b010, 4'b0101, 16'hBEEF, 3'b000, 8'h00);
      chk("mw_a", OutA16, 16'hBEEF);
      chk("mw_b", OutB16, 16'hBEEF);

      // Increment wrap at both sizes.
      do_op(3'b010, 4'b0010, 16'hFFFF, 3'b010, 8'hFF);
      do_op(3'b001, 4'b0010, 16'h0000, 3'b010, 8'h00);
      chk("inc_wrap16", {12'd0, Wrap16}, 16'h0002);
      chk("inc_wrap8", {13'd0, Wrap8}, 16'h0002);
      do_op(3'b001, 4'b0010, 16'h0000, 3'b010, 8'h00);
      chk("inc_hold16", {12'd0, Wrap16}, 16'h0002);
      do_op(3'b011, 4'b0010, 16'h0000, 3'b010, 8'h00);
      chk("clr_wrap16", {12'd0, Wrap16}, 16'h0000);

      // Decrement wrap.
      do_op(3'b011, 4'b0001, 16'h0000, 3'b000, 8'h00);
      do_op(3'b000, 4'b0001, 16'h0000, 3'b000, 8'h00);
      chk("dec_wrap", {15'd0, Wrap16[0]}, 16'h0001);
      do_op(3'b000, 4'b0001, 16'h0000, 3'b000, 8'h00);
      chk("dec_hold", {15'd0, Wrap16[0]}, 16'h0001);
      do_op(3'b010, 4'b0001, 16'h0005, 3'b000, 8'h00);
      chk("dec_clr", {15'd0, Wrap16[0]}, 16'h0000);

      // Half-word ops on R3.
      do_op(3'b010, 4'b1000, 16'h1234, 3'b000, 8'h00);
      do_op(3'b101, 4'b1000, 16'h00AB, 3'b000, 8'h00);
      chk_r3("half_101", 16'h12AB);
      do_op(3'b110, 4'b1000, 16'h00CD, 3'b000, 8'h00);
      chk_r3("half_110", 16'hCDAB);
      do_op(3'b100, 4'b1000, 16'hFF77, 3'b000, 8'h00);
      chk_r3("half_100", 16'h0077);
      do_op(3'b111, 4'b1000, 16'h0080, 3'b000, 8'h00);
      chk_r3("sext_neg", 16'hFF80);
      do_op(3'b111, 4'b1000, 16'h007F, 3'b000, 8'h00);
      chk_r3("sext_pos", 16'h007F);

      // Empty mask holds everything for every opcode.
      for (int f = 0; f < 8; f++)
         do_op(3'(f), 4'b0000, 16'($urandom), 3'b000, 8'($urandom));

      // Random operations with occasional mid-cycle resets.
      for (int n = 0; n < 400; n++) begin
         do_op(3'($urandom_range(0, 7)), 4'($urandom), 16'($urandom),
               3'($urandom), 8'($urandom));
         if ($urandom_range(0, 59) == 0) begin
            async_reset_check("rst_rand");
            Reset = 1'b1;
            #1;
         end
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/multi_register_bank.md
# multi_register_bank

Parametrised bank of DEPTH general-purpose registers, each WIDTH bits wide, that replaces single 16-bit registers in the datapath. Every register supports the established decrement, increment, load and clear operations, plus half-word loads and sign extension. A one-hot enable mask lets one operation hit any subset of registers in one cycle. The bank has two combinational read ports for the ALU operand path and a sticky per-register wrap flag for counter-style use (PC/AR/SP).

## Interface
- WIDTH, 16, register width in bits; even, ≥ 4; HALF = WIDTH/2.
- DEPTH, 4, number of registers; ≥ 2; SELW = $clog2(DEPTH).
- Clock  input  1  single clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- I  input  WIDTH  write data.
- FunSel  input  3  operation code (see Operation).
- RegSel  input  DEPTH  one-hot enable mask; bit i enables register i; any combination is legal.
- OutASel  input  SELW  read port A register index.
- OutBSel  input  SELW  read port B register index.
- OutA  output  WIDTH  contents of register OutASel.
- OutB  output  WIDTH  contents of register OutBSel.
- Wrap  output  DEPTH  sticky wrap flag per register.

## Operation
- Registers R0..R(DEPTH-1) update only on a rising Clock edge with Reset high and RegSel[i]=1. If RegSel[i]=0, register i holds its value.
- FunSel per enabled register, all arithmetic modulo 2^WIDTH:
  - 000 = R−1.
  - 001 = R+1.
  - 010 = I.
  - 011 = 0.
  - 100 = {0, I[HALF-1:0]}: load low half, clear high half.
  - 101 = {R[WIDTH-1:HALF], I[HALF-1:0]}: load low half, keep high half.
  - 110 = {I[HALF-1:0], R[HALF-1:0]}: load high half from the low half of I, keep low half.
  - 111 = sign-extend I[HALF-1:0] to WIDTH.
- All enabled registers perform the same operation on their own current value in the same edge.
- Wrap[i] rules:
  - Set on an enabled 001 when R = all-ones (result 0).
  - Set on an enabled 000 when R = 0 (result all-ones).
  - A non-wrapping 000/001 leaves it unchanged.
  - Any enabled 010, 011 or 100–111 clears it.
  - A disabled register keeps its flag.
- Read ports:
  - OutA and OutB are purely combinational muxes of current register state.
  - Both ports may select the same register.
  - A select value ≥ DEPTH (non-power-of-two DEPTH) drives all zeros.
- No write-through: during the cycle of a write, the ports show the pre-edge value.

## Timing
- Reset low forces all registers, Wrap, and hence OutA/OutB (for valid selects) to 0 immediately, independent of Clock. This holds mid-operation and on any FunSel/RegSel.
- First update occurs on the first rising edge with Reset high.
- Write latency is 1 edge. Read latency is 0: new values are visible on OutA/OutB after the edge, once combinational settling completes.
- Wrap updates on the same edge as its register.
- There are no illegal FunSel codes and no handshakes; the bank is always ready.

## Test plan
- Reset: load R0..R3=0x1111..0x4444, then pull Reset low between edges → all registers, OutA, OutB and Wrap read 0 before the next edge. A held Clock edge during reset produces no change.
- Multi-write: RegSel=0101, FunSel=010, I=0xBEEF → R0=R2=0xBEEF, R1=R3 unchanged. OutASel=2, OutBSel=2 both read 0xBEEF after the edge and the old value before it.
- Increment wrap: R1=0xFFFF, FunSel=001, RegSel=0010 → R1=0x0000, Wrap=0010. A second inc → 0x0001 with Wrap still 0010. FunSel=011 → R1=0, Wrap=0000.
- Decrement wrap: R0=0x0000, FunSel=000, RegSel=0001 → R0=0xFFFF, Wrap[0]=1. A further dec → 0xFFFE with flag held. FunSel=010, I=5 → flag cleared.
- Half ops on R3=0x1234:
  - 101, I=0x00AB → 0x12AB.
  - 110, I=0x00CD → 0xCDAB.
  - 100, I=0xFF77 → 0x0077.
  - 111, I=0x0080 → 0xFF80.
  - 111, I=0x007F → 0x007F.
- Hold/param: RegSel=0000 with every FunSel → no register or Wrap change. Repeat the increment-wrap test at WIDTH=8, DEPTH=3: 0xFF+1 → 0x00 with the flag set, and OutASel=3 → OutA=0.
